// File: rtl/voice_allocator.sv
// voice_allocator: assigns a stream of note requests to NUM_VOICES chord-player
// voices. A request takes the lowest-index idle voice. When every voice is busy,
// it takes the oldest busy voice. The voice_load pulse comes from a one-deep
// schedule stage, so a flush can still cancel it.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [NOTE_W-1:0]            req_note,
  input  logic [DUR_W-1:0]             req_duration,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*DUR_W-1:0]  voice_duration,
  input  logic [NUM_VOICES-1:0]        voice_done,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic                         steal
);

  localparam int SEL_W = $clog2(NUM_VOICES);
  localparam int AGE_W = SEL_W;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  typedef enum logic {V_IDLE = 1'b0, V_ACTIVE = 1'b1} voice_state_e;

  voice_state_e                  state_q [NUM_VOICES];
  voice_state_e                  state_d [NUM_VOICES];
  logic [AGE_W-1:0]              age_q   [NUM_VOICES];
  logic [AGE_W-1:0]              age_d   [NUM_VOICES];
  logic [NUM_VOICES*NOTE_W-1:0]  note_q, note_d;
  logic [NUM_VOICES*DUR_W-1:0]   dur_q, dur_d;
  logic [NUM_VOICES-1:0]         sched_q, sched_d;
  logic [NUM_VOICES-1:0]         load_q, load_d;
  logic                          sched_steal_q, sched_steal_d;
  logic                          steal_q, steal_d;

  logic                          alloc;
  logic                          found_idle;
  logic [SEL_W-1:0]              sel_idx;
  logic [AGE_W-1:0]              best_age;
  logic                          sel_active;
  logic                          sel_done;

  // Reset forces ready low even though reset is asynchronous to the request side.
  assign req_ready = reset & play & ~flush;
  assign alloc     = req_valid & req_ready & (req_note != '0);

  // Pick the target voice from registered state only: first idle, else oldest busy (ties -> lowest index).
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    sel_idx    = '0;
    found_idle = 1'b0;
    best_age   = age_q[0];
    sel_active = 1'b0;
    sel_done   = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found_idle && state_q[i] == V_IDLE) begin
        sel_idx    = SEL_W'(i);
        found_idle = 1'b1;
      end
    end
    if (!found_idle) begin
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (age_q[i] > best_age) begin
          best_age = age_q[i];
          sel_idx  = SEL_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (sel_idx == SEL_W'(i)) begin
        sel_active = (state_q[i] == V_ACTIVE);
        sel_done   = voice_done[i];
      end
    end
  end

  // Next voice state and age, latched note data, and the load/steal schedule pipeline.
  always_comb begin
    note_d        = note_q;
    dur_d         = dur_q;
    sched_d       = '0;
    // A voice that is finishing on this very edge is reused rather than stolen.
    sched_steal_d = alloc & sel_active & ~sel_done;
    load_d        = flush ? '0 : sched_q;
    steal_d       = ~flush & sched_steal_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      if (flush) begin
        state_d[i] = V_IDLE;
        age_d[i]   = '0;
      end else if (alloc && sel_idx == SEL_W'(i)) begin
        state_d[i]                    = V_ACTIVE;
        age_d[i]                      = '0;
        sched_d[i]                    = 1'b1;
        note_d[i*NOTE_W +: NOTE_W]    = req_note;
        dur_d[i*DUR_W +: DUR_W]       = req_duration;
      end else if (voice_done[i]) begin
        state_d[i] = V_IDLE;
        age_d[i]   = '0;
      end else if (alloc && state_q[i] == V_ACTIVE && age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  // State register for all voices and the output pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= V_IDLE;
        age_q[i]   <= '0;
      end
      // NOTE: the note/duration storage drives outputs, so it is reset to a known value like the control state.
      note_q        <= '0;
      dur_q         <= '0;
      sched_q       <= '0;
      load_q        <= '0;
      sched_steal_q <= 1'b0;
      steal_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments update all state together at the edge, so there are no ordering races.
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
      end
      note_q        <= note_d;
      dur_q         <= dur_d;
      sched_q       <= sched_d;
      load_q        <= load_d;
      sched_steal_q <= sched_steal_d;
      steal_q       <= steal_d;
    end
  end

  // Expose the registered per-voice activity.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_busy[i] = (state_q[i] == V_ACTIVE);
    end
  end

  assign voice_load     = load_q;
  assign steal          = steal_q;
  assign voice_note     = note_q;
  assign voice_duration = dur_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed stimulus. An integer-level allocation model is
// compared with the DUT on every negative clock edge. Hand-computed literals
// pin both the model and the DUT at key points.
module tb_voice_allocator;

  localparam int N  = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            play = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [NW-1:0]   req_note = '0;
  logic [DW-1:0]   req_duration = '0;
  logic [N-1:0]    voice_load;
  logic [N*NW-1:0] voice_note;
  logic [N*DW-1:0] voice_duration;
  logic [N-1:0]    voice_done = '0;
  logic [N-1:0]    voice_busy;
  logic            steal;

  int checks = 0;
  int failures = 0;

  // Model: per-voice busy flag, age, and stored data, plus the scheduled load waiting for its output edge.
  int m_busy [N];
  int m_age  [N];
  int m_note [N];
  int m_dur  [N];
  int m_pend;
  int m_pend_steal;
  int m_load;
  int m_steal;

  voice_allocator #(.NUM_VOICES(N), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .play(play), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_note(req_note), .req_duration(req_duration),
    .voice_load(voice_load), .voice_note(voice_note), .voice_duration(voice_duration),
    .voice_done(voice_done), .voice_busy(voice_busy), .steal(steal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_age[i] = 0; m_note[i] = 0; m_dur[i] = 0;
    end
    m_pend = -1; m_pend_steal = 0; m_load = 0; m_steal = 0;
  endtask

  task automatic model_step();
    int v;
    int ns;
    if (flush) begin
      m_load = 0; m_steal = 0;
    end else begin
      m_load  = (m_pend >= 0) ? (1 << m_pend) : 0;
      m_steal = m_pend_steal;
    end
    v = -1; ns = 0;
    if (flush) begin
      for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_age[i] = 0; end
    end else begin
      if (req_valid && play && req_note != 0) begin
        for (int i = 0; i < N; i++) if (v < 0 && m_busy[i] == 0) v = i;
        if (v < 0) begin
          v = 0;
          for (int i = 1; i < N; i++) if (m_age[i] > m_age[v]) v = i;
        end
        ns = (m_busy[v] != 0 && !voice_done[v]) ? 1 : 0;
        m_note[v] = int'(req_note);
        m_dur[v]  = int'(req_duration);
      end
      for (int i = 0; i < N; i++) begin
        if (i == v) begin
          m_busy[i] = 1; m_age[i] = 0;
        end else if (voice_done[i]) begin
          m_busy[i] = 0; m_age[i] = 0;
        end else if (v >= 0 && m_busy[i] != 0) begin
          m_age[i] = (m_age[i] + 1 > N - 1) ? N - 1 : m_age[i] + 1;
        end
      end
    end
    m_pend = v; m_pend_steal = ns;
  endtask

  function automatic logic [N-1:0] exp_busy();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = (m_busy[i] != 0);
    return b;
  endfunction

  function automatic logic [N*NW-1:0] exp_notes();
    logic [N*NW-1:0] p;
    for (int i = 0; i < N; i++) p[i*NW +: NW] = NW'(m_note[i]);
    return p;
  endfunction

  function automatic logic [N*DW-1:0] exp_durs();
    logic [N*DW-1:0] p;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = DW'(m_dur[i]);
    return p;
  endfunction

  // Model advance: sampled at the same edge as the DUT, from inputs that changed 1 time unit after the previous edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        check("req_ready", req_ready, play && !flush);
        check("voice_load", voice_load, m_load);
        check("steal", steal, m_steal);
        check("voice_busy", voice_busy, exp_busy());
        check("voice_note", voice_note, exp_notes());
        check("voice_duration", voice_duration, exp_durs());
      end
    end
  end

  task automatic step(input bit v, input int note, input int dur, input logic [N-1:0] done, input bit fl);
    req_valid = v; req_note = NW'(note); req_duration = DW'(dur);
    voice_done = done; flush = fl;
    @(posedge clk); #1;
    req_valid = 1'b0; req_note = '0; req_duration = '0;
    voice_done = '0; flush = 1'b0;
  endtask

  initial begin
    logic [N*NW-1:0] exp_n;
    #2 reset = 1'b0;
    #1;
    check("rst_load", voice_load, 0);
    check("rst_busy", voice_busy, 0);
    check("rst_steal", steal, 0);
    check("rst_note", voice_note, 0);
    check("rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; play = 1'b1;

    // Test 1: three requests fill voices 0,1,2 in order.
    step(1, 10, 4, '0, 0);
    check("t1_busy_a", voice_busy, 3'b001);
    check("t1_load_a", voice_load, 3'b000);
    step(1, 20, 4, '0, 0);
    check("t1_load_b", voice_load, 3'b001);
    step(1, 30, 4, '0, 0);
    check("t1_load_c", voice_load, 3'b010);
    check("t1_busy", voice_busy, 3'b111);
    step(0, 0, 0, '0, 0);
    check("t1_load_d", voice_load, 3'b100);
    check("t1_steal", steal, 0);
    exp_n = {6'd30, 6'd20, 6'd10};
    check("t1_notes", voice_note, exp_n);

    // Test 2: voice 0 is the oldest and is stolen.
    step(1, 40, 5, '0, 0);
    step(0, 0, 0, '0, 0);
    check("t2_load", voice_load, 3'b001);
    check("t2_steal", steal, 1);
    check("t2_note0", voice_note[5:0], 6'd40);
    check("t2_ages", {m_age[0], m_age[1], m_age[2]}, {32'd0, 32'd2, 32'd1});

    // Test 3: voice 1 (oldest) finishes on the allocation edge, so allocation wins and it is not a steal.
    step(1, 50, 3, 3'b010, 0);
    check("t3_busy", voice_busy, 3'b111);
    step(0, 0, 0, '0, 0);
    check("t3_load", voice_load, 3'b010);
    check("t3_steal", steal, 0);
    check("t3_note1", voice_note[11:6], 6'd50);
    check("t3_ages", {m_age[0], m_age[1], m_age[2]}, {32'd1, 32'd0, 32'd2});
    step(0, 0, 0, 3'b111, 0);
    check("t3_release", voice_busy, 3'b000);
    step(0, 0, 0, 3'b100, 0);
    check("done_idle_ignored", voice_busy, 3'b000);

    // Test 4: a rest is consumed without any load.
    req_valid = 1'b1; req_note = '0; #1;
    check("t4_ready", req_ready, 1);
    step(1, 0, 2, '0, 0);
    step(0, 0, 0, '0, 0);
    check("t4_load", voice_load, 3'b000);
    check("t4_busy", voice_busy, 3'b000);

    // Test 5: flush cancels the scheduled load, and the held request is not taken.
    step(1, 7, 1, '0, 0);
    check("t5_busy_pre", voice_busy, 3'b001);
    flush = 1'b1; req_valid = 1'b1; req_note = 6'd9; #1;
    check("t5_ready", req_ready, 0);
    step(1, 9, 1, '0, 1);
    check("t5_load", voice_load, 3'b000);
    check("t5_busy", voice_busy, 3'b000);
    step(0, 0, 0, '0, 0);
    check("t5_load_after", voice_load, 3'b000);
    check("t5_busy_after", voice_busy, 3'b000);

    // Test 6: pause blocks accepts, while a load already scheduled is still issued.
    step(1, 3, 2, '0, 0);
    play = 1'b0;
    step(1, 11, 1, '0, 0);
    check("t6_sched_load", voice_load, 3'b001);
    for (int k = 0; k < 9; k++) step(1, 11, 1, '0, 0);
    check("t6_pause_load", voice_load, 3'b000);
    check("t6_pause_busy", voice_busy, 3'b001);
    check("t6_pause_ready", req_ready, 0);
    play = 1'b1;
    step(1, 11, 1, '0, 0);
    check("t6_busy", voice_busy, 3'b011);
    step(0, 0, 0, '0, 0);
    check("t6_load", voice_load, 3'b010);
    check("t6_note1", voice_note[11:6], 6'd11);

    // Mid-operation reset drops the pending load at once.
    step(1, 12, 2, '0, 0);
    #2 reset = 1'b0;
    #1;
    check("mrst_busy", voice_busy, 3'b000);
    check("mrst_load", voice_load, 3'b000);
    check("mrst_note", voice_note, 0);
    check("mrst_ready", req_ready, 0);
    @(posedge clk); #1 reset = 1'b1;
    step(0, 0, 0, '0, 0);
    check("mrst_no_load", voice_load, 3'b000);
    step(0, 0, 0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
